message_stream_arbiter: RTL and testbench

- Successor to the fixed 4-stream message combiner.
- Merges N_STREAMS message streams into one output stream without interleaving packets, using round-robin arbitration at packet granularity.
- Adds output backpressure (out_ready), parametrised FIFO depth, per-stream fill flags, stray-word dropping and per-stream sticky error reporting.
- Sits between the per-channel message producers and the single message sink (e.g. the host link).

---
 rtl/message_stream_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_message_stream_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/message_stream_arbiter.sv
// rtl/message_stream_arbiter.sv - packet-granular round-robin merge of N message streams
// Per-stream FIFOs feed a two-state arbiter that never interleaves packets from different streams.
module message_stream_arbiter #(
    parameter int N_STREAMS             = 4,
    parameter int LOG_N_STREAMS         = 2,
    parameter int WIDTH                 = 32,
    parameter int LOG_DEPTH             = 6,
    parameter int AFULL_MARGIN          = 4,
    parameter int LOG_MAX_PACKET_LENGTH = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WIDTH*N_STREAMS-1:0]   in_data,
    input  logic [N_STREAMS-1:0]         in_nd,
    output logic [N_STREAMS-1:0]         in_afull,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_nd,
    input  logic                         out_ready,
    output logic [LOG_N_STREAMS-1:0]     out_stream,
    output logic [N_STREAMS-1:0]         err_overflow,
    output logic [N_STREAMS-1:0]         err_stray
);
    localparam int DEPTH = 1 << LOG_DEPTH;
    localparam int CNT_W = LOG_DEPTH + 1;
    localparam int LEN_W = LOG_MAX_PACKET_LENGTH;

    typedef enum logic {ST_IDLE, ST_PACKET} state_t;

    logic [WIDTH-1:0]         r_mem [N_STREAMS][DEPTH];
    logic [LOG_DEPTH-1:0]     r_wptr [N_STREAMS];
    logic [LOG_DEPTH-1:0]     r_rptr [N_STREAMS];
    logic [CNT_W-1:0]         r_count [N_STREAMS];
    logic [N_STREAMS-1:0]     r_afull;

    state_t                   r_state;
    logic [LOG_N_STREAMS-1:0] r_rr_ptr;
    logic [LOG_N_STREAMS-1:0] r_locked;
    logic [LEN_W-1:0]         r_remaining;
    logic [WIDTH-1:0]         r_out_data;
    logic                     r_out_nd;
    logic [LOG_N_STREAMS-1:0] r_out_stream;
    logic [N_STREAMS-1:0]     r_err_overflow;
    logic [N_STREAMS-1:0]     r_err_stray;

    logic [N_STREAMS-1:0]     w_full, w_empty, w_push, w_pop, w_stray;
    logic [CNT_W-1:0]         w_count_nxt [N_STREAMS];
    logic [N_STREAMS-1:0]     w_afull_nxt;
    logic                     w_found;
    logic [LOG_N_STREAMS-1:0] w_sel, w_src;
    logic [WIDTH-1:0]         w_head;
    logic [LEN_W-1:0]         w_len;
    logic                     w_slot_free, w_load;
    state_t                   w_state_nxt;
    logic [LOG_N_STREAMS-1:0] w_rr_nxt, w_locked_nxt;
    logic [LEN_W-1:0]         w_remaining_nxt;

    function automatic logic [LOG_N_STREAMS-1:0] f_wrap(input int v);
        return LOG_N_STREAMS'((v >= N_STREAMS) ? v - N_STREAMS : v);
    endfunction

    // Full is judged on the registered count, so a same-cycle pop never rescues a write.
    always_comb begin
        for (int j = 0; j < N_STREAMS; j++) begin
            w_full[j]  = (r_count[j] == CNT_W'(DEPTH));
            w_empty[j] = (r_count[j] == '0);
        end
    end

    assign w_push = in_nd & ~w_full;

    always_comb begin
        for (int j = 0; j < N_STREAMS; j++) begin
            w_count_nxt[j] = r_count[j];
            if (w_push[j] && !w_pop[j])
                w_count_nxt[j] = r_count[j] + CNT_W'(1);
            else if (!w_push[j] && w_pop[j])
                w_count_nxt[j] = r_count[j] - CNT_W'(1);
            w_afull_nxt[j] = (int'(w_count_nxt[j]) + AFULL_MARGIN) >= DEPTH;
        end
    end

    // Scan from the highest rotation offset down so the requester nearest rr_ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = N_STREAMS - 1; k >= 0; k--) begin
            if (!w_empty[f_wrap(int'(r_rr_ptr) + k)]) begin
                w_found = 1'b1;
                w_sel   = f_wrap(int'(r_rr_ptr) + k);
            end
        end
    end

    assign w_src       = (r_state == ST_PACKET) ? r_locked : w_sel;
    assign w_head      = r_mem[w_src][r_rptr[w_src]];
    assign w_len       = w_head[WIDTH-2 -: LEN_W];
    assign w_slot_free = !r_out_nd || out_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_rr_nxt        = r_rr_ptr;
        w_locked_nxt    = r_locked;
        w_remaining_nxt = r_remaining;
        w_pop           = '0;
        w_stray         = '0;
        w_load          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    if (!w_head[WIDTH-1]) begin
                        w_pop[w_sel]   = 1'b1;
                        w_stray[w_sel] = 1'b1;
                    end else if (w_slot_free) begin
                        w_pop[w_sel] = 1'b1;
                        w_load       = 1'b1;
                        if (w_len == '0) begin
                            w_rr_nxt = f_wrap(int'(w_sel) + 1);
                        end else begin
                            w_remaining_nxt = w_len;
                            w_locked_nxt    = w_sel;
                            w_state_nxt     = ST_PACKET;
                        end
                    end
                end
            end
            ST_PACKET: begin
                if (!w_empty[r_locked] && w_slot_free) begin
                    w_pop[r_locked] = 1'b1;
                    w_load          = 1'b1;
                    w_remaining_nxt = r_remaining - LEN_W'(1);
                    if (r_remaining == LEN_W'(1)) begin
                        w_state_nxt = ST_IDLE;
                        w_rr_nxt    = f_wrap(int'(r_locked) + 1);
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < N_STREAMS; j++)
            if (w_push[j])
                r_mem[j][r_wptr[j]] <= in_data[WIDTH*j +: WIDTH];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int j = 0; j < N_STREAMS; j++) begin
                r_wptr[j]  <= '0;
                r_rptr[j]  <= '0;
                r_count[j] <= '0;
            end
            r_afull <= '0;
        end else begin
            for (int j = 0; j < N_STREAMS; j++) begin
                if (w_push[j])
                    r_wptr[j] <= r_wptr[j] + LOG_DEPTH'(1);
                if (w_pop[j])
                    r_rptr[j] <= r_rptr[j] + LOG_DEPTH'(1);
                r_count[j] <= w_count_nxt[j];
            end
            r_afull <= w_afull_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_rr_ptr       <= '0;
            r_locked       <= '0;
            r_remaining    <= '0;
            r_out_data     <= '0;
            r_out_nd       <= 1'b0;
            r_out_stream   <= '0;
            r_err_overflow <= '0;
            r_err_stray    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_locked    <= w_locked_nxt;
            r_remaining <= w_remaining_nxt;
            if (w_load) begin
                r_out_data   <= w_head;
                r_out_nd     <= 1'b1;
                r_out_stream <= w_src;
            end else if (w_slot_free) begin
                r_out_nd <= 1'b0;
            end
            r_err_overflow <= r_err_overflow | (in_nd & w_full);
            r_err_stray    <= r_err_stray | w_stray;
        end
    end

    assign in_afull     = r_afull;
    assign out_data     = r_out_data;
    assign out_nd       = r_out_nd;
    assign out_stream   = r_out_stream;
    assign err_overflow = r_err_overflow;
    assign err_stray    = r_err_stray;
endmodule

// File: tb/tb_message_stream_arbiter.sv
// tb/tb_message_stream_arbiter.sv - directed and randomized bench with a queue-based reference model
module tb_message_stream_arbiter;
    localparam int N      = 4;
    localparam int W      = 32;
    localparam int LD     = 6;
    localparam int DEPTH  = 1 << LD;
    localparam int MARGIN = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [W*N-1:0] in_data;
    logic [N-1:0]   in_nd, in_afull, err_overflow, err_stray;
    logic [W-1:0]   out_data;
    logic           out_nd, out_ready;
    logic [1:0]     out_stream;

    logic [W*N-1:0] s_in_data;
    logic [N-1:0]   s_in_nd, s_in_afull, s_err_overflow, s_err_stray;
    logic [W-1:0]   s_out_data;
    logic           s_out_nd, s_out_ready;
    logic [1:0]     s_out_stream;

    always #5 clk = ~clk;

    message_stream_arbiter #(.N_STREAMS(N), .LOG_N_STREAMS(2), .WIDTH(W), .LOG_DEPTH(LD),
                             .AFULL_MARGIN(MARGIN), .LOG_MAX_PACKET_LENGTH(10)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_nd(in_nd), .in_afull(in_afull),
        .out_data(out_data), .out_nd(out_nd), .out_ready(out_ready), .out_stream(out_stream),
        .err_overflow(err_overflow), .err_stray(err_stray));

    message_stream_arbiter #(.N_STREAMS(N), .LOG_N_STREAMS(2), .WIDTH(W), .LOG_DEPTH(2),
                             .AFULL_MARGIN(4), .LOG_MAX_PACKET_LENGTH(10)) u_small (
        .clk(clk), .rst_n(rst_n), .in_data(s_in_data), .in_nd(s_in_nd), .in_afull(s_in_afull),
        .out_data(s_out_data), .out_nd(s_out_nd), .out_ready(s_out_ready), .out_stream(s_out_stream),
        .err_overflow(s_err_overflow), .err_stray(s_err_stray));

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: plain queues plus packet-level bookkeeping
    logic [W-1:0] mq [N][$];
    bit           m_in_pkt;
    int           m_locked, m_rem, m_rr;
    logic [W-1:0] m_out_data;
    bit           m_out_nd;
    int           m_out_stream;
    logic [N-1:0] m_ovf, m_stray, m_afull;

    logic [W-1:0] cap_d [$];
    logic [1:0]   cap_s [$];
    logic [W-1:0] exp_d [$];
    int           exp_s [$];
    logic [W-1:0] s_cap [$];
    logic [W-1:0] gen [N][$];
    bit           rdy_pat [12] = '{1, 1, 1, 0, 0, 1, 0, 1, 1, 1, 1, 1};

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] hdr(input int len, input int tag);
        return {1'b1, 10'(len), 21'(tag)};
    endfunction

    task automatic model_update();
        int           sz [N];
        bit           slot, present;
        logic [W-1:0] w;
        int           s;
        if (!rst_n) begin
            for (int j = 0; j < N; j++) mq[j].delete();
            m_in_pkt = 0; m_rr = 0; m_locked = 0; m_rem = 0;
            m_out_nd = 0; m_out_data = '0; m_out_stream = 0;
            m_ovf = '0; m_stray = '0; m_afull = '0;
            return;
        end
        for (int j = 0; j < N; j++) sz[j] = mq[j].size();
        slot    = !m_out_nd || out_ready;
        present = 0;
        if (!m_in_pkt) begin
            s = -1;
            for (int k = 0; k < N; k++)
                if (s < 0 && sz[(m_rr + k) % N] > 0) s = (m_rr + k) % N;
            if (s >= 0) begin
                w = mq[s][0];
                if (!w[W-1]) begin
                    void'(mq[s].pop_front());
                    m_stray[s] = 1'b1;
                end else if (slot) begin
                    void'(mq[s].pop_front());
                    present = 1; m_out_data = w; m_out_stream = s;
                    if (w[30:21] == 10'd0) m_rr = (s + 1) % N;
                    else begin m_in_pkt = 1; m_locked = s; m_rem = int'(w[30:21]); end
                end
            end
        end else if (sz[m_locked] > 0 && slot) begin
            w = mq[m_locked].pop_front();
            present = 1; m_out_data = w; m_out_stream = m_locked;
            m_rem--;
            if (m_rem == 0) begin m_in_pkt = 0; m_rr = (m_locked + 1) % N; end
        end
        if (present) m_out_nd = 1;
        else if (slot) m_out_nd = 0;
        for (int j = 0; j < N; j++)
            if (in_nd[j]) begin
                if (sz[j] == DEPTH) m_ovf[j] = 1'b1;
                else mq[j].push_back(in_data[W*j +: W]);
            end
        for (int j = 0; j < N; j++) m_afull[j] = (DEPTH - mq[j].size()) <= MARGIN;
    endtask

    task automatic step();
        if (out_nd && out_ready) begin cap_d.push_back(out_data); cap_s.push_back(out_stream); end
        if (s_out_nd && s_out_ready) s_cap.push_back(s_out_data);
        model_update();
        @(posedge clk);
        #1;
        chk("out_nd", 32'(out_nd), 32'(m_out_nd));
        chk("out_data", out_data, m_out_data);
        chk("out_stream", 32'(out_stream), 32'(m_out_stream));
        chk("in_afull", 32'(in_afull), 32'(m_afull));
        chk("err_overflow", 32'(err_overflow), 32'(m_ovf));
        chk("err_stray", 32'(err_stray), 32'(m_stray));
    endtask

    task automatic expect_word(input logic [W-1:0] d, input int s);
        exp_d.push_back(d);
        exp_s.push_back(s);
    endtask

    task automatic check_caps(input string tag);
        chk({tag, "_count"}, 32'(cap_d.size()), 32'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && i < cap_d.size(); i++) begin
            chk({tag, "_data"}, cap_d[i], exp_d[i]);
            chk({tag, "_stream"}, 32'(cap_s[i]), 32'(exp_s[i]));
        end
        cap_d.delete(); cap_s.delete(); exp_d.delete(); exp_s.delete();
    endtask

    function automatic bit model_idle();
        for (int j = 0; j < N; j++) if (mq[j].size() != 0 || gen[j].size() != 0) return 0;
        return !m_in_pkt && !m_out_nd;
    endfunction

    initial begin
        logic [W-1:0] prev_data;
        logic         prev_nd, prev_rdy;
        int           len, guard;

        rst_n = 1'b0; in_nd = '0; in_data = '0; out_ready = 1'b1;
        s_in_nd = '0; s_in_data = '0; s_out_ready = 1'b0;
        step(); step();
        chk("rst_out_nd", 32'(out_nd), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_in_afull", 32'(in_afull), 32'd0);
        rst_n = 1'b1;

        // Basic packet: latency of two cycles, three consecutive words
        in_nd = 4'b0001; in_data[31:0] = hdr(2, 1); step();
        chk("t1_lat_nd", 32'(out_nd), 32'd0);
        in_data[31:0] = 32'h11; step();
        chk("t1_hdr_nd", 32'(out_nd), 32'd1);
        chk("t1_hdr", out_data, hdr(2, 1));
        chk("t1_stream", 32'(out_stream), 32'd0);
        in_data[31:0] = 32'h22; step();
        chk("t1_p1", out_data, 32'h11);
        in_nd = '0; step();
        chk("t1_p2", out_data, 32'h22);
        step();
        chk("t1_end_nd", 32'(out_nd), 32'd0);
        cap_d.delete(); cap_s.delete();

        // Two simultaneous packets are served whole, in round-robin order
        in_nd = 4'b1010; in_data[63:32] = hdr(1, 2); in_data[127:96] = hdr(1, 3); step();
        in_data[63:32] = 32'hA1; in_data[127:96] = 32'hA3; step();
        in_nd = '0; repeat (8) step();
        expect_word(hdr(1, 2), 1); expect_word(32'hA1, 1);
        expect_word(hdr(1, 3), 3); expect_word(32'hA3, 3);
        check_caps("t2");

        // Locked stream stalls the output while another stream waits
        in_nd = 4'b0100; in_data[95:64] = hdr(3, 4); step();
        in_nd = 4'b0001; in_data[31:0] = hdr(0, 5); step();
        in_nd = '0; repeat (5) step();
        for (int i = 0; i < 3; i++) begin
            in_nd = 4'b0100; in_data[95:64] = 32'hB0 + 32'(i); step();
        end
        in_nd = '0; repeat (6) step();
        expect_word(hdr(3, 4), 2);
        for (int i = 0; i < 3; i++) expect_word(32'hB0 + 32'(i), 2);
        expect_word(hdr(0, 5), 0);
        check_caps("t3");

        // Backpressure: every word exactly once and held stable while stalled
        for (int i = 0; i < 12; i++) begin
            in_nd = (i < 4) ? 4'b0010 : 4'b0000;
            case (i)
                0: in_data[63:32] = hdr(3, 6);
                1: in_data[63:32] = 32'hC1;
                2: in_data[63:32] = 32'h8000_00C2;
                default: in_data[63:32] = 32'hC3;
            endcase
            out_ready = rdy_pat[i];
            prev_data = out_data; prev_nd = out_nd; prev_rdy = out_ready;
            step();
            if (prev_nd && !prev_rdy) chk("t4_stable", out_data, prev_data);
        end
        out_ready = 1'b1;
        expect_word(hdr(3, 6), 1); expect_word(32'hC1, 1);
        expect_word(32'h8000_00C2, 1); expect_word(32'hC3, 1);
        check_caps("t4");

        // Non-header word at a packet boundary is dropped and flagged
        in_nd = 4'b0010; in_data[63:32] = 32'h0000_0005; step();
        in_nd = '0; step(); step();
        chk("stray_flag", 32'(err_stray), 32'h2);
        check_caps("stray");

        // Overflow on a depth-4 instance while the sink refuses words
        for (int i = 0; i < 6; i++) begin
            s_in_nd = 4'b0001;
            s_in_data[31:0] = (i == 0) ? hdr(4, 7) : 32'hD0 + 32'(i);
            step();
        end
        s_in_nd = '0; step();
        chk("ovf_flag", 32'(s_err_overflow), 32'h1);
        chk("ovf_afull", 32'(s_in_afull), 32'hF);
        chk("ovf_hold_nd", 32'(s_out_nd), 32'd1);
        chk("ovf_hold_data", s_out_data, hdr(4, 7));
        s_cap.delete();
        s_out_ready = 1'b1;
        repeat (10) step();
        chk("ovf_count", 32'(s_cap.size()), 32'd5);
        if (s_cap.size() == 5) begin
            chk("ovf_w0", s_cap[0], hdr(4, 7));
            for (int i = 1; i < 5; i++) chk("ovf_wn", s_cap[i], 32'hD0 + 32'(i));
        end

        // Randomized traffic against the reference model
        for (int c = 0; c < 2500; c++) begin
            in_nd = '0;
            for (int j = 0; j < N; j++) begin
                if (gen[j].size() == 0) begin
                    if ($urandom_range(0, 9) == 0) gen[j].push_back({1'b0, 31'($urandom)});
                    else begin
                        len = int'($urandom_range(0, 5));
                        gen[j].push_back(hdr(len, int'($urandom_range(0, 1000))));
                        for (int p = 0; p < len; p++) gen[j].push_back($urandom);
                    end
                end
                if (!in_afull[j] && $urandom_range(0, 1) == 1) begin
                    in_nd[j] = 1'b1;
                    in_data[W*j +: W] = gen[j].pop_front();
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        guard = 0;
        while (!model_idle() && guard < 3000) begin
            in_nd = '0;
            for (int j = 0; j < N; j++)
                if (gen[j].size() != 0 && !in_afull[j]) begin
                    in_nd[j] = 1'b1;
                    in_data[W*j +: W] = gen[j].pop_front();
                end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
            guard++;
        end
        chk("rand_drained", 32'(model_idle()), 32'd1);
        in_nd = '0; out_ready = 1'b1;

        // Reset in the middle of a packet, then a leftover payload is stray
        for (int i = 0; i < 3; i++) begin
            in_nd = 4'b0001; in_data[31:0] = (i == 0) ? hdr(5, 8) : 32'hE0 + 32'(i); step();
        end
        in_nd = '0; step();
        rst_n = 1'b0; step();
        chk("mid_rst_nd", 32'(out_nd), 32'd0);
        chk("mid_rst_data", out_data, 32'd0);
        chk("mid_rst_stray", 32'(err_stray), 32'd0);
        chk("mid_rst_ovf", 32'(s_err_overflow), 32'd0);
        chk("mid_rst_afull", 32'(in_afull), 32'd0);
        rst_n = 1'b1;
        cap_d.delete(); cap_s.delete();
        in_nd = 4'b0001; in_data[31:0] = 32'h0000_0077; step();
        in_nd = '0; step(); step();
        chk("post_rst_stray", 32'(err_stray), 32'h1);
        check_caps("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
